// File: rtl/soc_mem_pkg.sv
// Shared constants and encodings for the SoC SRAM arbiter (soc_mem_arbiter).
// Optional round-robin arbitration is enabled with `define SOC_MEM_ARB_RR_EN.
package soc_mem_pkg;

    localparam int WORDS_DEFAULT  = 16;
    localparam int MEM_AW_DEFAULT = 22;

    // Requester indices into the req/gnt vectors.
    localparam int REQ_M0 = 0;  // instruction fetch
    localparam int REQ_M1 = 1;  // data / LSU

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } resp_state_e;

endpackage

// File: rtl/soc_mem_arb_pick.sv
// Two-way request picker producing a one-hot grant.
// SOC_MEM_ARB_RR_EN selects round-robin; otherwise m1 has fixed priority.
module soc_mem_arb_pick
    import soc_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef SOC_MEM_ARB_RR_EN
    always_comb begin
        gnt = '0;
        if (&req) begin
            // Conflict: hand the grant to whoever did not win last time.
            if (last_grant == 1'(REQ_M1)) gnt[REQ_M0] = 1'b1;
            else                          gnt[REQ_M1] = 1'b1;
        end else begin
            gnt = req;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt = '0;
        if (req[REQ_M1]) gnt[REQ_M1] = 1'b1;
        else             gnt[REQ_M0] = req[REQ_M0];
    end
`endif

endmodule

// File: rtl/soc_mem_arbiter.sv
// Shares one single-port SRAM between Ibex fetch (m0) and LSU (m1), with bounds checking.
// Define SOC_MEM_ARB_RR_EN for round-robin arbitration; default is fixed m1 priority.
module soc_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int WORDS  = WORDS_DEFAULT,
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_be,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic              mem_ena,
    output logic [3:0]        mem_wen,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic [1:0]  req, pick_gnt, gnt;
    logic        last_grant;
    logic        any_gnt, in_range;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [29:0] sel_word;
    logic [31:0] sel_wdata;

    resp_state_e state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        rd_ok;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    assign req = {m1_req, m0_req};

    soc_mem_arb_pick u_pick (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (pick_gnt)
    );

    // Nothing may be granted while reset is held, even with requests pending.
    assign gnt     = pick_gnt & {2{resetn}};
    assign any_gnt = |gnt;
    assign m0_gnt  = gnt[REQ_M0];
    assign m1_gnt  = gnt[REQ_M1];

    always_comb begin
        sel_we    = m0_we;
        sel_be    = m0_be;
        sel_word  = m0_addr[31:2];
        sel_wdata = m0_wdata;
        if (gnt[REQ_M1]) begin
            sel_we    = m1_we;
            sel_be    = m1_be;
            sel_word  = m1_addr[31:2];
            sel_wdata = m1_wdata;
        end
        // Full-width compare so high addresses cannot alias into the SRAM.
        in_range = {2'b00, sel_word} < 32'(WORDS);

        mem_ena   = 1'b0;
        mem_wen   = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_gnt) begin
            mem_addr  = sel_word[MEM_AW-1:0];
            mem_wdata = sel_wdata;
            if (in_range) begin
                mem_ena = 1'b1;
                mem_wen = sel_we ? sel_be : 4'b0000;
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        owner_d = gnt;
        we_d    = any_gnt & sel_we;
        err_d   = any_gnt & ~in_range;
        if (any_gnt) state_d = RESP;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

`ifdef SOC_MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[REQ_M1])      last_grant_d = 1'(REQ_M1);
        else if (gnt[REQ_M0]) last_grant_d = 1'(REQ_M0);
    end

    // Reset to m1 so m0 wins the first conflict.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_grant_q <= 1'(REQ_M1);
        else         last_grant_q <= last_grant_d;
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'(REQ_M1);
`endif

    // Only in-range reads return SRAM data; writes and errors return zero.
    assign rd_ok     = (state_q == RESP) & ~we_q & ~err_q;
    assign m0_rvalid = (state_q == RESP) & owner_q[REQ_M0];
    assign m1_rvalid = (state_q == RESP) & owner_q[REQ_M1];
    assign m0_rdata  = (m0_rvalid & rd_ok) ? mem_rdata : '0;
    assign m1_rdata  = (m1_rvalid & rd_ok) ? mem_rdata : '0;
    assign m0_err    = m0_rvalid & err_q;
    assign m1_err    = m1_rvalid & err_q;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter with an SRAM model and a response scoreboard.
module tb_soc_mem_arbiter;

    localparam int WORDS  = 16;
    localparam int MEM_AW = 22;
`ifdef SOC_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    logic m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [3:0] m0_be, m1_be, mem_wen;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic mem_ena;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    soc_mem_arbiter #(.WORDS(WORDS), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read, byte-lane writes.
    logic [31:0] mem [0:WORDS-1];
    always @(posedge clk) begin
        if (mem_ena) begin
            for (int i = 0; i < 4; i++)
                if (mem_wen[i]) mem[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata <= mem[mem_addr[3:0]];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: every cycle either the due response or silence.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                if (e.owner == 0) begin
                    chk("m0_rvalid", {31'd0, m0_rvalid}, 1);
                    chk("m0_rdata", m0_rdata, e.data);
                    chk("m0_err", {31'd0, m0_err}, {31'd0, e.err});
                    chk("m1_quiet", {m1_rvalid, m1_err, m1_rdata[29:0]}, 0);
                end else begin
                    chk("m1_rvalid", {31'd0, m1_rvalid}, 1);
                    chk("m1_rdata", m1_rdata, e.data);
                    chk("m1_err", {31'd0, m1_err}, {31'd0, e.err});
                    chk("m0_quiet", {m0_rvalid, m0_err, m0_rdata[29:0]}, 0);
                end
            end else begin
                chk("no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
            end
        end
    end

    task automatic drive(input int m, input logic rq, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (m == 0) begin
            m0_req = rq; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = rq; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1 with req dropped.
    task automatic xfer(input int m, input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_err);
        bit ok = 1'b0;
        drive(m, 1'b1, we, be, addr, wd);
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = (m == 0) ? (m0_gnt === 1'b1) : (m1_gnt === 1'b1);
        end
        chk("gnt_seen", {31'd0, ok}, 1);
        if (ok) begin
            sbq.push_back('{owner: m, data: exp_d, err: exp_err, due: cyc + 1});
            chk("mem_ena", {31'd0, mem_ena}, {31'd0, ~exp_err});
            chk("mem_wen", {28'd0, mem_wen}, {28'd0, (!exp_err && we) ? be : 4'b0000});
            if (!exp_err) begin
                chk("mem_addr", {10'd0, mem_addr}, {10'd0, addr[23:2]});
                chk("mem_wdata", mem_wdata, wd);
            end
        end
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int exp_m;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        resetn = 1'b0;
        #12;
        chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
        chk("rst_mem_ena", {31'd0, mem_ena}, 0);
        chk("rst_resp", {m0_rvalid, m0_err, m1_rvalid, m1_err}, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Full-word write then read back on m0.
        xfer(0, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0);
        // Single-lane write on m1.
        xfer(1, 1'b1, 4'b0010, 32'h8, 32'h0000AB00, 32'h0, 1'b0);
        xfer(1, 1'b0, 4'hF, 32'h8, 32'h0, 32'hDEADABEF, 1'b0);

        // Contention for 6 cycles: m0 reads word 0, m1 reads word 1.
        xfer(0, 1'b1, 4'hF, 32'h0, 32'hA0A0A0A0, 32'h0, 1'b0);
        xfer(1, 1'b1, 4'hF, 32'h4, 32'hB1B1B1B1, 32'h0, 1'b0);
        exp_m = RR ? 0 : 1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
            drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
            @(negedge clk);
            chk("conf_m0_gnt", {31'd0, m0_gnt}, (exp_m == 0) ? 1 : 0);
            chk("conf_m1_gnt", {31'd0, m1_gnt}, (exp_m == 1) ? 1 : 0);
            sbq.push_back('{owner: exp_m, data: (exp_m == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1,
                            err: 1'b0, due: cyc + 1});
            if (RR) exp_m = 1 - exp_m;
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Bounds: word 16 errors, word 15 is last valid, high address must not alias.
        xfer(0, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1);
        xfer(0, 1'b0, 4'hF, 32'h40, 32'h0, 32'h0, 1'b1);
        xfer(1, 1'b0, 4'hF, 32'h0100_0008, 32'h0, 32'h0, 1'b1);
        xfer(0, 1'b1, 4'hF, 32'h3C, 32'h12345678, 32'h0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h3C, 32'h0, 32'h12345678, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'hA0A0A0A0, 1'b0);

        // Back-to-back reads of words 0,1,2.
        xfer(1, 1'b1, 4'hF, 32'h8, 32'hC2C2C2C2, 32'h0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'hA0A0A0A0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h4, 32'h0, 32'hB1B1B1B1, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h8, 32'h0, 32'hC2C2C2C2, 1'b0);
        @(posedge clk); #1;

        // Reset between grant and response drops the response.
        drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        @(negedge clk);
        chk("mid_m1_gnt", {31'd0, m1_gnt}, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
        chk("mid_rst_mem", {27'd0, mem_ena, mem_wen}, 0);
        @(posedge clk); #1;
        chk("mid_rst_resp", {m0_rvalid, m0_err, m1_rvalid, m1_err}, 0);
        chk("mid_rst_rdata", m0_rdata | m1_rdata, 0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // First conflict after reset.
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        @(negedge clk);
        exp_m = RR ? 0 : 1;
        chk("post_rst_m0_gnt", {31'd0, m0_gnt}, (exp_m == 0) ? 1 : 0);
        chk("post_rst_m1_gnt", {31'd0, m1_gnt}, (exp_m == 1) ? 1 : 0);
        sbq.push_back('{owner: exp_m, data: (exp_m == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1,
                        err: 1'b0, due: cyc + 1});
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_mem_arbiter.md
Name: soc_mem_arbiter

Overview:
- Shares one single-port SoC SRAM between two bus requesters: m0 (Ibex instruction fetch) and m1 (Ibex data/LSU).
- The SRAM has a 1-cycle registered read, byte-lane write enables and a word address.
- Requester side uses a req/gnt/rvalid protocol, one outstanding transfer per granted cycle.
- The block arbitrates, translates byte address to word address, checks address bounds, and steers the response back to its owner.

Parameters:
- WORDS, 16: SRAM depth in 32-bit words; word index >= WORDS is out of range.
- MEM_AW, 22: SRAM word-address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  transfer request
- m0_we, m1_we  in  1  1=write, 0=read
- m0_be, m1_be  in  4  byte enables, lane i = bits [8i+7:8i]
- m0_addr, m1_addr  in  32  byte address; bits [1:0] ignored
- m0_wdata, m1_wdata  in  32  write data
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1  response valid, one cycle after gnt
- m0_rdata, m1_rdata  out  32  read data, valid with rvalid
- m0_err, m1_err  out  1  out-of-range error, valid with rvalid
- mem_ena  out  1  SRAM enable
- mem_wen  out  4  SRAM byte write enables
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, registered inside SRAM

Behaviour:
- Reset, async on resetn low:
  - rvalid, err and rdata of both requesters = 0.
  - Response-owner register = none.
  - last_grant = m1, so m0 wins the first conflict.
  - gnt and mem_ena are forced 0 while resetn is low.
- Grant:
  - At most one gnt per cycle. A lone requester is granted in the same cycle.
  - No waiting states; a non-granted requester holds req and its signals until gnt.
- Address:
  - word = addr[31:2].
  - In range iff word < WORDS. Compare at full width; no wrap or truncation before the compare.
  - mem_addr = word[MEM_AW-1:0].
- Granted, in range:
  - mem_ena = 1; mem_addr, mem_wdata from the winner.
  - mem_wen = be if we, else 4'b0000.
- Granted, out of range: mem_ena = 0, mem_wen = 0 (SRAM untouched); error recorded.
- Not granted: mem_ena = 0, mem_wen = 0, mem_addr and mem_wdata = 0.
- Response, cycle N+1 after a grant in cycle N:
  - Owner's rvalid = 1 for exactly one cycle, reads and writes alike.
  - Read in range: rdata = mem_rdata, err = 0.
  - Write: rdata = 0.
  - Out of range: rdata = 0, err = 1.
  - Non-owner's rvalid, rdata and err = 0.
- Back-to-back grants give rvalid every cycle, so full throughput is 1 transfer/cycle. Responses are never stalled.
- Reset asserted mid-transfer: the pending response is dropped and no rvalid follows.
- Registered state: resp_valid, resp_owner, resp_we, resp_err, last_grant. These form a 2-state response FSM, IDLE and RESP: a grant moves it to RESP, and no grant moves it to IDLE.

Optional Feature:
- SOC_MEM_ARB_RR_EN defined: round-robin arbitration.
  - On conflict (both req), grant the requester not in last_grant.
  - last_grant updates on every grant, including uncontended ones.
- SOC_MEM_ARB_RR_EN undefined: fixed priority, m1 (data) always beats m0; the last_grant register is not built.

Decomposition:
- Package soc_mem_pkg:
  - constants MEM_AW and WORDS defaults;
  - requester index localparams REQ_M0 = 0, REQ_M1 = 1;
  - response-state encoding IDLE/RESP.
- Sub-module soc_mem_arb_pick: 2-way picker, inputs req[1:0] and last_grant, output one-hot grant.
  - Contains both the round-robin and fixed-priority variants under the macro.

Test Plan:
- m0 write addr 0x8, be 4'b1111, wdata 0xDEADBEEF, then m0 read addr 0x8 → the write asserts mem_wen = 4'hF and mem_addr = 2; the read gives rdata 0xDEADBEEF at gnt+1, err = 0.
- m1 write be 4'b0010 wdata 0x0000AB00 to word 2, then read → 0xDEADABEF.
- Both req every cycle for 6 cycles:
  - with RR_EN, grants alternate m0, m1, m0, …;
  - without RR_EN, all 6 go to m1 and m0_gnt stays 0.
- m0 read addr 0x40 (word 16, WORDS = 16) → mem_ena = 0; m0_rvalid = 1 with err = 1 and rdata = 0 next cycle. m0 addr 0x3C → normal access.
- Back-to-back reads m0 words 0,1,2 → rvalid on 3 consecutive cycles, data in order.
- Grant an m1 read, pulse resetn low before the next edge → no m1_rvalid; all outputs 0 during reset; the first conflict after reset goes to m0.
